// File: rtl/cntr_reconfig_pkg.sv
// Shared types, reset defaults and mode-string helper for the PLL counter reconfiguration sequencer.
package cntr_reconfig_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BYPASS = 2'd1,
    MODE_EVEN   = 2'd2,
    MODE_ODD    = 2'd3
  } mode_e;

  localparam logic [47:0] STR_OFF    = "   off";
  localparam logic [47:0] STR_BYPASS = "bypass";
  localparam logic [47:0] STR_EVEN   = "  even";
  localparam logic [47:0] STR_ODD    = "   odd";

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ASSERT_RST = 3'd1,
    LOAD       = 3'd2,
    RELEASE    = 3'd3,
    DONE       = 3'd4
  } state_e;

  localparam logic [7:0] DEF_HIGH = 8'd1;
  localparam logic [7:0] DEF_LOW  = 8'd1;
  localparam logic [7:0] DEF_INIT = 8'd1;
  localparam mode_e      DEF_MODE = MODE_OFF;

  // One counter's configuration; field order matches the readback word layout.
  typedef struct packed {
    mode_e      mode;
    logic [7:0] init;
    logic [7:0] low;
    logic [7:0] high;
  } cntr_cfg_t;

  localparam cntr_cfg_t DEF_CFG = '{mode: DEF_MODE, init: DEF_INIT, low: DEF_LOW, high: DEF_HIGH};

  function automatic logic [47:0] mode_str(input mode_e m);
    mode_str = STR_OFF;
    case (m)
      MODE_BYPASS: mode_str = STR_BYPASS;
      MODE_EVEN:   mode_str = STR_EVEN;
      MODE_ODD:    mode_str = STR_ODD;
      default:     mode_str = STR_OFF;
    endcase
  endfunction

endpackage

// File: rtl/cycloneiiigl_cntr_reconfig_ctrl_if.sv
// Config/apply handshake and counter-drive bus; CNTR_RECONFIG_READBACK_EN adds the readback port.
interface cycloneiiigl_cntr_reconfig_ctrl_if #(
  parameter int unsigned NUM_CNTR = 5
) ();
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [2:0]             cfg_sel;
  logic [7:0]             cfg_high;
  logic [7:0]             cfg_low;
  logic [7:0]             cfg_init;
  logic [1:0]             cfg_mode;
  logic                   cfg_err;
  logic                   apply_req;
  logic                   busy;
  logic                   done;
  logic [NUM_CNTR-1:0]    cntr_reset;
  logic [NUM_CNTR*32-1:0] cntr_high;
  logic [NUM_CNTR*32-1:0] cntr_low;
  logic [NUM_CNTR*32-1:0] cntr_init;
  logic [NUM_CNTR*48-1:0] cntr_mode;
`ifdef CNTR_RECONFIG_READBACK_EN
  logic [2:0]             rd_sel;
  logic                   rd_active;
  logic [26:0]            rd_data;
`endif

  modport slave (
    input  cfg_valid, cfg_sel, cfg_high, cfg_low, cfg_init, cfg_mode, apply_req,
    output cfg_ready, cfg_err, busy, done, cntr_reset, cntr_high, cntr_low, cntr_init, cntr_mode
`ifdef CNTR_RECONFIG_READBACK_EN
    , input rd_sel, rd_active, output rd_data
`endif
  );

  modport master (
    output cfg_valid, cfg_sel, cfg_high, cfg_low, cfg_init, cfg_mode, apply_req,
    input  cfg_ready, cfg_err, busy, done, cntr_reset, cntr_high, cntr_low, cntr_init, cntr_mode
`ifdef CNTR_RECONFIG_READBACK_EN
    , output rd_sel, rd_active, input rd_data
`endif
  );
endinterface

// File: rtl/cntr_cfg_slot.sv
// Shadow/active/dirty storage for one scale counter; CNTR_RECONFIG_READBACK_EN exposes raw state.
module cntr_cfg_slot
  import cntr_reconfig_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  cntr_cfg_t   i_cfg,
  input  logic        i_commit,
  output logic        o_dirty,
  output logic [31:0] o_high,
  output logic [31:0] o_low,
  output logic [31:0] o_init,
  output logic [47:0] o_mode
`ifdef CNTR_RECONFIG_READBACK_EN
  , output cntr_cfg_t o_shadow
  , output cntr_cfg_t o_active
`endif
);

  cntr_cfg_t   r_shadow;
  cntr_cfg_t   r_active;
  logic        r_dirty;
  logic [47:0] r_mode_str;

  // Writes only happen in IDLE and commits only in LOAD, so the two never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow   <= DEF_CFG;
      r_active   <= DEF_CFG;
      r_dirty    <= 1'b0;
      r_mode_str <= mode_str(DEF_MODE);
    end else if (i_we) begin
      r_shadow <= i_cfg;
      r_dirty  <= 1'b1;
    end else if (i_commit && r_dirty) begin
      r_active   <= r_shadow;
      r_mode_str <= mode_str(r_shadow.mode);
      r_dirty    <= 1'b0;
    end
  end

  assign o_dirty = r_dirty;
  assign o_high  = 32'(r_active.high);
  assign o_low   = 32'(r_active.low);
  assign o_init  = 32'(r_active.init);
  assign o_mode  = r_mode_str;
`ifdef CNTR_RECONFIG_READBACK_EN
  assign o_shadow = r_shadow;
  assign o_active = r_active;
`endif

endmodule

// File: rtl/cycloneiiigl_cntr_reconfig_ctrl.sv
// Run-time reconfiguration sequencer for the PLL C-counters: shadow writes, reset-commit-release apply.
// Optional readback port enabled by CNTR_RECONFIG_READBACK_EN.
module cycloneiiigl_cntr_reconfig_ctrl
  import cntr_reconfig_pkg::*;
#(
  parameter int unsigned NUM_CNTR      = 5,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input logic clk,
  input logic reset,
  cycloneiiigl_cntr_reconfig_ctrl_if.slave bus
);

  localparam int unsigned WAIT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CW       = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] REL_LOAD = (SETTLE_CYCLES == 0) ? '0 : CW'(SETTLE_CYCLES - 1);

  state_e                 r_state, w_state_n;
  logic [CW-1:0]          r_wait, w_wait_n;
  logic [NUM_CNTR-1:0]    r_cntr_reset, w_cntr_reset_n;
  logic [NUM_CNTR-1:0]    w_dirty, w_we;
  logic                   r_cfg_ready, r_busy, r_done, r_cfg_err;
  logic                   w_accept, w_cfg_ok, w_commit;
  cntr_cfg_t              w_cfg;
  logic [NUM_CNTR*32-1:0] w_high, w_low, w_init;
  logic [NUM_CNTR*48-1:0] w_mode;

  assign w_accept = bus.cfg_valid && r_cfg_ready;
  assign w_cfg_ok = (32'(bus.cfg_sel) < NUM_CNTR)
                 && !(bus.cfg_mode[1] && ((bus.cfg_high == 8'd0) || (bus.cfg_low == 8'd0)))
                 && (bus.cfg_init != 8'd0);
  assign w_cfg    = '{mode: mode_e'(bus.cfg_mode), init: bus.cfg_init, low: bus.cfg_low, high: bus.cfg_high};
  assign w_commit = (r_state == LOAD);

`ifdef CNTR_RECONFIG_READBACK_EN
  cntr_cfg_t   w_shd [NUM_CNTR];
  cntr_cfg_t   w_act [NUM_CNTR];
  logic [26:0] r_rd_data, w_rd_data_n;
`endif

  for (genvar gi = 0; gi < NUM_CNTR; gi++) begin : g_slot
    assign w_we[gi] = w_accept && w_cfg_ok && (bus.cfg_sel == 3'(gi));
    cntr_cfg_slot u_slot (
      .clk      (clk),
      .reset    (reset),
      .i_we     (w_we[gi]),
      .i_cfg    (w_cfg),
      .i_commit (w_commit),
      .o_dirty  (w_dirty[gi]),
      .o_high   (w_high[32*gi +: 32]),
      .o_low    (w_low[32*gi +: 32]),
      .o_init   (w_init[32*gi +: 32]),
      .o_mode   (w_mode[48*gi +: 48])
`ifdef CNTR_RECONFIG_READBACK_EN
      , .o_shadow (w_shd[gi])
      , .o_active (w_act[gi])
`endif
    );
  end

  // Next-state; a write landing in the same IDLE cycle as apply_req joins that apply.
  always_comb begin
    w_state_n      = r_state;
    w_wait_n       = r_wait;
    w_cntr_reset_n = r_cntr_reset;
    unique case (r_state)
      IDLE: begin
        if (bus.apply_req) begin
          if (|(w_dirty | w_we)) begin
            w_state_n      = ASSERT_RST;
            w_wait_n       = RST_LOAD;
            w_cntr_reset_n = w_dirty | w_we;
          end else begin
            w_state_n = DONE;
          end
        end
      end
      ASSERT_RST: begin
        if (r_wait == '0) w_state_n = LOAD;
        else              w_wait_n  = r_wait - CW'(1);
      end
      LOAD: begin
        w_cntr_reset_n = '0;
        if (SETTLE_CYCLES == 0) begin
          w_state_n = DONE;
        end else begin
          w_state_n = RELEASE;
          w_wait_n  = REL_LOAD;
        end
      end
      RELEASE: begin
        if (r_wait == '0) w_state_n = DONE;
        else              w_wait_n  = r_wait - CW'(1);
      end
      DONE:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_n;
      r_wait  <= w_wait_n;
    end
  end

  // Status outputs follow the state being entered on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cntr_reset <= '0;
      r_cfg_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_cntr_reset <= w_cntr_reset_n;
      r_cfg_ready  <= (w_state_n == IDLE);
      r_busy       <= (w_state_n != IDLE);
      r_done       <= (w_state_n == DONE);
      r_cfg_err    <= w_accept && !w_cfg_ok;
    end
  end

`ifdef CNTR_RECONFIG_READBACK_EN
  always_comb begin
    w_rd_data_n = '0;
    for (int i = 0; i < NUM_CNTR; i++) begin
      if (bus.rd_sel == 3'(i)) w_rd_data_n = {w_dirty[i], bus.rd_active ? w_act[i] : w_shd[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_rd_data <= '0;
    else       r_rd_data <= w_rd_data_n;
  end

  assign bus.rd_data = r_rd_data;
`endif

  assign bus.cfg_ready  = r_cfg_ready;
  assign bus.cfg_err    = r_cfg_err;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.cntr_reset = r_cntr_reset;
  assign bus.cntr_high  = w_high;
  assign bus.cntr_low   = w_low;
  assign bus.cntr_init  = w_init;
  assign bus.cntr_mode  = w_mode;

endmodule

// File: tb/tb_cycloneiiigl_cntr_reconfig_ctrl.sv
// Self-checking bench: directed plus random writes/applies against a table-level reference model.
module tb_cycloneiiigl_cntr_reconfig_ctrl;
  localparam int NUM = 5;
  localparam int R   = 4;
  localparam int S   = 8;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  cycloneiiigl_cntr_reconfig_ctrl_if #(.NUM_CNTR(NUM)) bus ();

  cycloneiiigl_cntr_reconfig_ctrl #(.NUM_CNTR(NUM), .RST_CYCLES(R), .SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Reference model: per-counter shadow/active tables and a dirty mask.
  logic [7:0]     m_sh_h [NUM], m_sh_l [NUM], m_sh_i [NUM];
  logic [1:0]     m_sh_m [NUM];
  logic [7:0]     m_ac_h [NUM], m_ac_l [NUM], m_ac_i [NUM];
  logic [1:0]     m_ac_m [NUM];
  logic [NUM-1:0] m_dirty;

  function automatic void model_reset();
    for (int n = 0; n < NUM; n++) begin
      m_sh_h[n] = 8'd1; m_sh_l[n] = 8'd1; m_sh_i[n] = 8'd1; m_sh_m[n] = 2'd0;
      m_ac_h[n] = 8'd1; m_ac_l[n] = 8'd1; m_ac_i[n] = 8'd1; m_ac_m[n] = 2'd0;
    end
    m_dirty = '0;
  endfunction

  function automatic bit model_write(input int s, input logic [7:0] h, l, i, input logic [1:0] m);
    bit rej;
    rej = (s >= NUM) || ((m >= 2'd2) && (h == 8'd0 || l == 8'd0)) || (i == 8'd0);
    if (!rej) begin
      m_sh_h[s] = h; m_sh_l[s] = l; m_sh_i[s] = i; m_sh_m[s] = m;
      m_dirty[s] = 1'b1;
    end
    return rej;
  endfunction

  function automatic void model_commit();
    for (int n = 0; n < NUM; n++) begin
      if (m_dirty[n]) begin
        m_ac_h[n] = m_sh_h[n]; m_ac_l[n] = m_sh_l[n]; m_ac_i[n] = m_sh_i[n]; m_ac_m[n] = m_sh_m[n];
      end
    end
    m_dirty = '0;
  endfunction

  function automatic logic [47:0] mstr(input logic [1:0] m);
    case (m)
      2'd1:    return "bypass";
      2'd2:    return "  even";
      2'd3:    return "   odd";
      default: return "   off";
    endcase
  endfunction

  function automatic logic [255:0] exp_bus(input int kind);
    logic [255:0] v;
    v = '0;
    for (int n = 0; n < NUM; n++) begin
      case (kind)
        0:       v[32*n +: 32] = 32'(m_ac_h[n]);
        1:       v[32*n +: 32] = 32'(m_ac_l[n]);
        2:       v[32*n +: 32] = 32'(m_ac_i[n]);
        default: v[48*n +: 48] = mstr(m_ac_m[n]);
      endcase
    end
    return v;
  endfunction

  function automatic logic [26:0] rd_exp(input int s, input bit act);
    if (s >= NUM) return '0;
    if (act) return {m_dirty[s], m_ac_m[s], m_ac_i[s], m_ac_l[s], m_ac_h[s]};
    return {m_dirty[s], m_sh_m[s], m_sh_i[s], m_sh_l[s], m_sh_h[s]};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_actives(input string tag);
    chk({tag, ".high"}, 256'(bus.cntr_high), exp_bus(0));
    chk({tag, ".low"},  256'(bus.cntr_low),  exp_bus(1));
    chk({tag, ".init"}, 256'(bus.cntr_init), exp_bus(2));
    chk({tag, ".mode"}, 256'(bus.cntr_mode), exp_bus(3));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input int s, input logic [7:0] h, l, i, input logic [1:0] m);
    bus.cfg_valid = 1'b1;
    bus.cfg_sel   = 3'(s);
    bus.cfg_high  = h;
    bus.cfg_low   = l;
    bus.cfg_init  = i;
    bus.cfg_mode  = m;
  endtask

  task automatic do_write(input int s, input logic [7:0] h, l, i, input logic [1:0] m);
    bit rej;
    drive_wr(s, h, l, i, m);
    rej = model_write(s, h, l, i, m);
    tick();
    bus.cfg_valid = 1'b0;
    chk("wr.cfg_err", 256'(bus.cfg_err), 256'(rej));
    chk("wr.cfg_ready", 256'(bus.cfg_ready), 256'(1'b1));
    tick();
    chk("wr.cfg_err_clear", 256'(bus.cfg_err), 256'(1'b0));
    chk("wr.cntr_reset", 256'(bus.cntr_reset), 256'(0));
    chk_actives("wr.active");
  endtask

  // Apply with optional same-cycle write and optional extra apply_req while busy.
  task automatic run_apply(input bit with_wr, input int s, input logic [7:0] h, l, i,
                           input logic [1:0] m, input bit mid_pulse);
    logic [NUM-1:0] mask;
    bit             rej;
    int             lat;
    int             ndone;
    rej = 1'b0;
    if (with_wr) begin
      drive_wr(s, h, l, i, m);
      rej = model_write(s, h, l, i, m);
    end
    mask  = m_dirty;
    lat   = (mask != '0) ? (R + S + 3) : 2;
    ndone = 0;
    bus.apply_req = 1'b1;
    for (int k = 1; k <= lat + 1; k++) begin
      tick();
      if (k == 1) begin
        bus.apply_req = 1'b0;
        bus.cfg_valid = 1'b0;
        if (with_wr) chk("ap.cfg_err", 256'(bus.cfg_err), 256'(rej));
      end
      if (mask != '0 && k == R + 2) model_commit();
      if (mask == '0 && k == 1) model_commit();
      if (k <= R || k >= R + 2) chk_actives("ap.active");
      chk("ap.cntr_reset", 256'(bus.cntr_reset), (mask != '0 && k <= R + 1) ? 256'(mask) : 256'(0));
      chk("ap.busy", 256'(bus.busy), 256'(k <= lat - 1));
      chk("ap.done", 256'(bus.done), 256'(k == lat - 1));
      chk("ap.cfg_ready", 256'(bus.cfg_ready), 256'(k >= lat));
      if (bus.done) ndone++;
      if (mid_pulse) bus.apply_req = (k == 4);
    end
    chk("ap.done_count", 256'(ndone), 256'(1));
  endtask

  initial begin
    reset         = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_sel   = '0;
    bus.cfg_high  = '0;
    bus.cfg_low   = '0;
    bus.cfg_init  = '0;
    bus.cfg_mode  = '0;
    bus.apply_req = 1'b0;
`ifdef CNTR_RECONFIG_READBACK_EN
    bus.rd_sel    = '0;
    bus.rd_active = 1'b0;
`endif
    model_reset();

    // Reset values, then cfg_ready one cycle after release.
    tick();
    tick();
    chk("rst.cfg_ready", 256'(bus.cfg_ready), 256'(1'b0));
    chk("rst.busy", 256'(bus.busy), 256'(1'b0));
    chk("rst.done", 256'(bus.done), 256'(1'b0));
    chk("rst.cfg_err", 256'(bus.cfg_err), 256'(1'b0));
    chk("rst.cntr_reset", 256'(bus.cntr_reset), 256'(0));
    chk_actives("rst.active");
`ifdef CNTR_RECONFIG_READBACK_EN
    chk("rst.rd_data", 256'(bus.rd_data), 256'(0));
`endif
    reset = 1'b0;
    tick();
    chk("idle.cfg_ready", 256'(bus.cfg_ready), 256'(1'b1));
    chk_actives("idle.active");

    // Single odd-mode counter reconfiguration.
    do_write(2, 8'd3, 8'd2, 8'd1, 2'd3);
    run_apply(1'b0, 0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);

    // Rejected writes, then an apply with nothing dirty.
    do_write(5, 8'd4, 8'd4, 8'd4, 2'd1);
    do_write(1, 8'd0, 8'd4, 8'd1, 2'd2);
    do_write(0, 8'd4, 8'd4, 8'd0, 2'd1);
    run_apply(1'b0, 0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);

    // Same-cycle write + apply, with an ignored second apply_req mid-sequence.
    run_apply(1'b1, 0, 8'd7, 8'd6, 8'd2, 2'd2, 1'b1);

    // Bypass with zero high/low is legal.
    do_write(4, 8'd0, 8'd0, 8'd9, 2'd1);
    run_apply(1'b0, 0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);

    // Reset during ASSERT_RST aborts without a done pulse.
    do_write(3, 8'd10, 8'd11, 8'd12, 2'd3);
    bus.apply_req = 1'b1;
    tick();
    bus.apply_req = 1'b0;
    tick();
    chk("abort.cntr_reset_pre", 256'(bus.cntr_reset), 256'(m_dirty));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    chk("abort.cntr_reset", 256'(bus.cntr_reset), 256'(0));
    chk("abort.busy", 256'(bus.busy), 256'(1'b0));
    chk("abort.done", 256'(bus.done), 256'(1'b0));
    chk_actives("abort.active");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort.no_done", 256'(bus.done), 256'(1'b0));
      chk("abort.busy_low", 256'(bus.busy), 256'(1'b0));
    end
    chk("abort.cfg_ready", 256'(bus.cfg_ready), 256'(1'b1));
    run_apply(1'b0, 0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);

    // Random write batches and applies.
    for (int rnd = 0; rnd < 6; rnd++) begin
      int nw;
      nw = int'($urandom_range(1, 3));
      for (int w = 0; w < nw; w++) begin
        do_write(int'($urandom_range(0, 6)),
                 ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                 ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                 ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                 2'($urandom_range(0, 3)));
      end
      run_apply(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
                8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

`ifdef CNTR_RECONFIG_READBACK_EN
    // Readback of shadow vs active around an apply.
    do_write(1, 8'd5, 8'd7, 8'd2, 2'd2);
    bus.rd_sel = 3'd1;
    bus.rd_active = 1'b0;
    tick();
    chk("rd.shadow", 256'(bus.rd_data), 256'(rd_exp(1, 1'b0)));
    bus.rd_active = 1'b1;
    tick();
    chk("rd.active_pre", 256'(bus.rd_data), 256'(rd_exp(1, 1'b1)));
    bus.rd_sel = 3'd6;
    tick();
    chk("rd.out_of_range", 256'(bus.rd_data), 256'(0));
    run_apply(1'b0, 0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    bus.rd_sel = 3'd1;
    tick();
    chk("rd.active_post", 256'(bus.rd_data), 256'(rd_exp(1, 1'b1)));
    chk("rd.high_post", 256'(bus.rd_data[7:0]), 256'(8'd5));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
